// File: rtl/imm_ext_pipe.sv
// Pipelined immediate/displacement extender: zero-, sign-, left-align and
// sign-extend-then-word-shift modes, one-cycle latency behind a skid buffer.
module imm_ext_pipe #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 32,
    parameter int FW_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [FW_W-1:0]  in_fw,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    // Returns {err, data}; an out-of-range width falls back to the full field.
    function automatic logic [OUT_W:0] ext_imm(
        input logic [IN_W-1:0] imm,
        input logic [FW_W-1:0] fw_raw,
        input logic [1:0]      mode
    );
        logic             err;
        int               fwi;
        logic [OUT_W-1:0] m;
        logic [OUT_W-1:0] sx;
        logic [OUT_W-1:0] d;
        logic             s;
        err = (fw_raw == '0) || (fw_raw > FW_W'(IN_W));
        fwi = err ? IN_W : int'(fw_raw);
        m   = '0;
        s   = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (i < fwi)      m[i] = imm[i];
            if (i == fwi - 1) s    = imm[i];
        end
        sx = m;
        for (int i = 0; i < OUT_W; i++) begin
            if (i >= fwi) sx[i] = s;
        end
        case (mode)
            2'd0:    d = m;
            2'd1:    d = sx;
            2'd2:    d = m << (OUT_W - fwi);
            default: d = sx << 2;
        endcase
        return {err, d};
    endfunction

    logic [OUT_W:0]   w_ext_p0;
    logic [OUT_W-1:0] w_data_p0;
    logic             w_err_p0;
    logic             w_accept_p0;
    logic             w_out_free;

    logic             r_vld_p1;
    logic [OUT_W-1:0] r_data_p1;
    logic             r_err_p1;
    logic             r_skid_vld_p1;
    logic [OUT_W-1:0] r_skid_data_p1;
    logic             r_skid_err_p1;

    // Stage p0: combinational extension of the presented beat
    assign w_ext_p0    = ext_imm(in_imm, in_fw, in_mode);
    assign w_data_p0   = w_ext_p0[OUT_W-1:0];
    assign w_err_p0    = w_ext_p0[OUT_W];
    assign w_accept_p0 = in_valid & in_ready & ~flush;
    assign w_out_free  = ~r_vld_p1 | out_ready;

    // Stage p1: output register with one-entry skid behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1       <= 1'b0;
            r_data_p1      <= '0;
            r_err_p1       <= 1'b0;
            r_skid_vld_p1  <= 1'b0;
            r_skid_data_p1 <= '0;
            r_skid_err_p1  <= 1'b0;
        end else if (flush) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_vld_p1) begin
                r_vld_p1      <= 1'b1;
                r_data_p1     <= r_skid_data_p1;
                r_err_p1      <= r_skid_err_p1;
                r_skid_vld_p1 <= 1'b0;
            end else if (w_accept_p0) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_data_p0;
                r_err_p1  <= w_err_p0;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end else if (w_accept_p0) begin
            r_skid_vld_p1  <= 1'b1;
            r_skid_data_p1 <= w_data_p0;
            r_skid_err_p1  <= w_err_p0;
        end
    end

    assign in_ready  = ~r_skid_vld_p1;
    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_err   = r_err_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: extension modes, width fallback,
// backpressure ordering, flush and asynchronous reset.
module tb_imm_ext_pipe;
    localparam int IN_W  = 22;
    localparam int OUT_W = 32;
    localparam int FW_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [IN_W-1:0]  in_imm = '0;
    logic [FW_W-1:0]  in_fw = '0;
    logic [1:0]       in_mode = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_err;
    logic [OUT_W-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .FW_W(FW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_fw     (in_fw),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input int fw, input logic [IN_W-1:0] imm);
        in_valid = 1'b1;
        in_mode  = mode;
        in_fw    = fw[FW_W-1:0];
        in_imm   = imm;
    endtask

    task automatic single(input string tag, input logic [1:0] mode, input int fw,
                          input logic [IN_W-1:0] imm, input logic [31:0] exp_d,
                          input logic exp_e);
        @(negedge clk);
        out_ready = 1'b1;
        drive(mode, fw, imm);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, 64'(out_data), 64'(exp_d));
        chk({tag, ".err"}, 64'(out_err), 64'(exp_e));
    endtask

    // Leaves the output register holding a and the skid holding b.
    task automatic fill_two(input logic [IN_W-1:0] a, input int fwa, input logic [IN_W-1:0] b);
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'd0, fwa, a);
        @(negedge clk);
        drive(2'd0, 22, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.data", 64'(out_data), 64'd0);
        chk("rst.err", 64'(out_err), 64'd0);
        chk("rst.rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.vld", 64'(out_valid), 64'd0);

        single("sx16", 2'd1, 16, 22'h00000F, 32'h0000000F, 1'b0);
        single("sx13", 2'd1, 13, 22'h001FFF, 32'hFFFFFFFF, 1'b0);
        single("sx13g", 2'd1, 13, 22'h3FEFFF, 32'h00000FFF, 1'b0);
        single("sx13f", 2'd1, 13, 22'h3FFFFF, 32'hFFFFFFFF, 1'b0);
        single("zx13", 2'd0, 13, 22'h3FFFFF, 32'h00001FFF, 1'b0);
        single("la22", 2'd2, 22, 22'h3FFFFF, 32'hFFFFFC00, 1'b0);
        single("la1", 2'd2, 1, 22'h3FFFFF, 32'h80000000, 1'b0);
        single("sh22n", 2'd3, 22, 22'h200000, 32'hFF800000, 1'b0);
        single("sh22p", 2'd3, 22, 22'h000001, 32'h00000004, 1'b0);
        single("sx1", 2'd1, 1, 22'h000001, 32'hFFFFFFFF, 1'b0);
        single("bad0", 2'd1, 0, 22'h200000, 32'hFFE00000, 1'b1);
        single("bad31", 2'd1, 31, 22'h200000, 32'hFFE00000, 1'b1);
        single("bad23", 2'd0, 23, 22'h3FFFFF, 32'h003FFFFF, 1'b1);
        single("ok22", 2'd0, 22, 22'h3FFFFF, 32'h003FFFFF, 1'b0);
        single("ok5", 2'd1, 5, 22'h000010, 32'hFFFFFFF0, 1'b0);

        // Backpressure: A to out, B to skid, C held off until space frees.
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'd0, 22, 22'd1);
        @(negedge clk);
        chk("bp.rdyA", 64'(in_ready), 64'd1);
        drive(2'd0, 22, 22'd2);
        @(negedge clk);
        chk("bp.rdyB", 64'(in_ready), 64'd0);
        chk("bp.outA", 64'(out_data), 64'd1);
        drive(2'd0, 22, 22'd3);
        @(negedge clk);
        chk("bp.holdA", 64'(out_data), 64'd1);
        chk("bp.holdV", 64'(out_valid), 64'd1);
        chk("bp.rdyC", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.outB", 64'(out_data), 64'd2);
        chk("bp.vldB", 64'(out_valid), 64'd1);
        chk("bp.rdy1", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.outC", 64'(out_data), 64'd3);
        chk("bp.vldC", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("bp.drain", 64'(out_valid), 64'd0);

        // Flush with out and skid full and a beat presented.
        fill_two(22'h11, 22, 22'h22);
        flush = 1'b1;
        drive(2'd0, 22, 22'h33);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.vld", 64'(out_valid), 64'd0);
        chk("fl.rdy", 64'(in_ready), 64'd1);
        chk("fl.keep", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl.gone1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("fl.gone2", 64'(out_valid), 64'd0);

        // Flush must win over an accept that in_ready would otherwise allow.
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'd0, 22, 22'h44);
        @(negedge clk);
        flush = 1'b1;
        drive(2'd0, 22, 22'h55);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flp.vld", 64'(out_valid), 64'd0);
        chk("flp.rdy", 64'(in_ready), 64'd1);
        chk("flp.keep", 64'(out_data), 64'h44);
        @(negedge clk);
        chk("flp.gone", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle with out (err set) and skid full.
        fill_two(22'h200000, 0, 22'h66);
        chk("ar.pre", 64'(out_err), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.vld", 64'(out_valid), 64'd0);
        chk("ar.data", 64'(out_data), 64'd0);
        chk("ar.err", 64'(out_err), 64'd0);
        chk("ar.rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar.gone", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
